regfile_rv: RTL

- Integer register file and operand-supply end of the RV32I execute interface.
- Consumes the rs1/rs2/rd indices the ALU stage decodes and returns registered rs1_value/rs2_value operands.
- Accepts rd/rd_result writeback from the ALU.
- Keeps a busy scoreboard per register so an instruction is not issued against a pending destination; raises stall instead.

---
 rtl/regfile_rv_if.sv | 34 +++
 rtl/regfile_rv.sv | 78 +++++++
 2 files changed

// File: rtl/regfile_rv_if.sv
// rtl/regfile_rv_if.sv - issue, operand and writeback signals between decoder/ALU and register file
//   master: decoder/ALU side (drives issue indices and writeback, observes stall and operands)
//   slave : register file side
//   enable/rs1/rs2/rd      issue request and its register indices
//   stall                  issue refused this cycle (combinational)
//   rs1_value/rs2_value    registered operands
//   operands_valid         operands belong to the issue accepted on the previous edge
//   wb_enable/wb_rd/wb_data writeback from the ALU, never back-pressured
interface regfile_rv_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            enable;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            stall;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic            operands_valid;
    logic            wb_enable;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output enable, rs1, rs2, rd, wb_enable, wb_rd, wb_data,
        input  stall, rs1_value, rs2_value, operands_valid
    );

    modport slave (
        input  enable, rs1, rs2, rd, wb_enable, wb_rd, wb_data,
        output stall, rs1_value, rs2_value, operands_valid
    );
endinterface

// File: rtl/regfile_rv.sv
// rtl/regfile_rv.sv - RV32I integer register file with busy scoreboard and registered operand read
//   clock  rising-edge system clock
//   reset  asynchronous active-high reset; clears array, busy bits and operand outputs
//   bus    regfile_rv_if.slave: issue indices in, stall/operands out, writeback in
module regfile_rv #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic        clock,
    input  logic        reset,
    regfile_rv_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_eff;
    logic [NREG-1:0] busy_next;
    logic            wb_write;
    logic            accept;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // Index 0 reads as zero; a same-cycle writeback to the index is forwarded.
    function automatic logic [XLEN-1:0] operand(input logic [AW-1:0] idx);
        if (idx == '0)
            return '0;
        else if (bus.wb_enable && bus.wb_rd == idx)
            return bus.wb_data;
        else
            return regs[idx];
    endfunction

    assign wb_write = bus.wb_enable && (bus.wb_rd != '0);

    // A writeback landing this cycle retires the hazard, so it does not stall.
    always_comb begin
        busy_eff = '0;
        for (int i = 0; i < NREG; i++)
            busy_eff[i] = busy[i] && !(bus.wb_enable && bus.wb_rd == AW'(i));
    end

    // busy[0] is never set, so index 0 cannot contribute to a stall.
    assign bus.stall = bus.enable &&
                       (busy_eff[bus.rs1] || busy_eff[bus.rs2] || busy_eff[bus.rd]);
    assign accept    = bus.enable && !bus.stall;
    assign op1       = operand(bus.rs1);
    assign op2       = operand(bus.rs2);

    // Issue set is applied after the writeback clear so it wins on the same index.
    always_comb begin
        busy_next = busy;
        if (wb_write)
            busy_next[bus.wb_rd] = 1'b0;
        if (accept && bus.rd != '0)
            busy_next[bus.rd] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy               <= '0;
            bus.rs1_value      <= '0;
            bus.rs2_value      <= '0;
            bus.operands_valid <= 1'b0;
        end else begin
            bus.operands_valid <= accept;
            if (accept) begin
                bus.rs1_value <= op1;
                bus.rs2_value <= op2;
            end
            if (wb_write)
                regs[bus.wb_rd] <= bus.wb_data;
            busy <= busy_next;
        end
    end
endmodule
